interpolation_line_buffer: RTL and testbench

Multi-line, single-clock line buffer feeding the bilinear scaler: it stores up to LINE_NUM complete video lines in a ring and returns the same column from two vertically adjacent lines per read. It is the parametrised successor of the single-line interpolation RAM and sits between the pixel input stage and the vertical interpolation arithmetic. It adds line-level flow control (occupancy count, ready flags, sticky error flags) and a frame-start clear.

---
 rtl/interp_lb_pkg.sv | 34 +++
 rtl/interp_lb_bank.sv | 35 +++
 rtl/interpolation_line_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_interpolation_line_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_lb_pkg.sv
// Shared definitions for the interpolation line buffer.
// Build option: INTERP_LB_OUTREG_EN adds an output register after the bank
// mux, raising read latency from 1 to 2 cycles.
package interp_lb_pkg;

    localparam int unsigned LINE_NUM_MIN = 32'd2;
    localparam int unsigned LINE_NUM_MAX = 32'd8;
    // Wide enough to hold any line index up to LINE_NUM_MAX-1.
    localparam int unsigned PTR_W        = 32'd3;

`ifdef INTERP_LB_OUTREG_EN
    localparam int unsigned RD_LAT = 32'd2;
`else
    localparam int unsigned RD_LAT = 32'd1;
`endif

    // True when the ring size is one the design supports.
    function automatic logic line_num_ok(input int unsigned n);
        return (n >= LINE_NUM_MIN) && (n <= LINE_NUM_MAX);
    endfunction

    // Advance a ring pointer, wrapping from n-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned n);
        logic [PTR_W-1:0] nxt;
        if (32'(ptr) == (n - 32'd1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/interp_lb_bank.sv
// One line of storage: simple dual-port RAM, single write port and a
// registered read port. Data is deliberately not reset.
module interp_lb_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Store one pixel per accepted write.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read, held between read requests.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/interpolation_line_buffer.sv
// Ring of LINE_NUM line memories feeding the vertical interpolator. Each
// read returns the same column from the oldest line and the one after it.
// Build option: INTERP_LB_OUTREG_EN inserts a register after the bank mux.
module interpolation_line_buffer
    import interp_lb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int LINE_NUM   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_line_done,
    output logic                          wr_ready,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic                          rd_line_adv,
    output logic                          rd_ready,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data0,
    output logic [DATA_WIDTH-1:0]         rd_data1,
    output logic [$clog2(LINE_NUM+1)-1:0] line_cnt,
    output logic                          wr_ovf,
    output logic                          rd_unf
);

    localparam int CNT_W = $clog2(LINE_NUM + 1);

    if (!line_num_ok(LINE_NUM)) begin : g_bad_line_num
        $error("interpolation_line_buffer: LINE_NUM must be within 2..8");
    end

    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_base_q,  rd_base_d;
    logic [ADDR_WIDTH-1:0] wr_col_q,   wr_col_d;
    logic [CNT_W-1:0]      line_cnt_q, line_cnt_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_ready_q, rd_ready_d;
    logic                  wr_ovf_q,   wr_ovf_d;
    logic                  rd_unf_q,   rd_unf_d;
    // Line indices captured with each read; they steer the bank mux when
    // the RAM data appears, so a release in the meantime cannot disturb it.
    logic [PTR_W-1:0]      sel0_q,     sel0_d;
    logic [PTR_W-1:0]      sel1_q,     sel1_d;
    logic                  vld1_q,     vld1_d;

    logic wr_acc_s, commit_acc_s, rd_acc_s, rel_acc_s, hold_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [LINE_NUM];
    logic [DATA_WIDTH-1:0] mux0_s, mux1_s;

    assign hold_s       = rst | sof;
    assign wr_acc_s     = wr_en & wr_ready_q;
    assign commit_acc_s = wr_line_done & wr_ready_q;
    assign rd_acc_s     = rd_en & rd_ready_q;
    assign rel_acc_s    = rd_line_adv & (line_cnt_q != '0);

    // Next state for pointers, occupancy, ready flags and sticky errors.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_base_d  = rd_base_q;
        wr_col_d   = wr_col_q;
        line_cnt_d = line_cnt_q;
        sel0_d     = sel0_q;
        sel1_d     = sel1_q;

        if (wr_acc_s) begin
            wr_col_d = wr_col_q + ADDR_WIDTH'(1);
        end else begin
            wr_col_d = wr_col_q;
        end

        // A commit overrides the column increment: a same-cycle pixel has
        // already gone to the old line, and the new line starts at column 0.
        if (commit_acc_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q, LINE_NUM);
            wr_col_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rel_acc_s) begin
            rd_base_d = ptr_inc(rd_base_q, LINE_NUM);
        end else begin
            rd_base_d = rd_base_q;
        end

        case ({commit_acc_s, rel_acc_s})
            2'b10:   line_cnt_d = line_cnt_q + CNT_W'(1);
            2'b01:   line_cnt_d = line_cnt_q - CNT_W'(1);
            default: line_cnt_d = line_cnt_q;
        endcase

        // Reads use the pre-release base so a same-cycle release is safe.
        if (rd_acc_s) begin
            sel0_d = rd_base_q;
            sel1_d = ptr_inc(rd_base_q, LINE_NUM);
        end else begin
            sel0_d = sel0_q;
            sel1_d = sel1_q;
        end

        vld1_d     = rd_acc_s;
        wr_ready_d = (line_cnt_d < CNT_W'(LINE_NUM));
        rd_ready_d = (line_cnt_d >= CNT_W'(2));
        wr_ovf_d   = wr_ovf_q | ((wr_en | wr_line_done) & ~wr_ready_q);
        rd_unf_d   = rd_unf_q | (rd_en & ~rd_ready_q)
                              | (rd_line_adv & (line_cnt_q == '0));
    end

    // Control state register; reset wins over frame start.
    always_ff @(posedge clk) begin
        if (rst || sof) begin
            wr_ptr_q   <= '0;
            rd_base_q  <= '0;
            wr_col_q   <= '0;
            line_cnt_q <= '0;
            wr_ready_q <= 1'b1;
            rd_ready_q <= 1'b0;
            wr_ovf_q   <= 1'b0;
            rd_unf_q   <= 1'b0;
            sel0_q     <= '0;
            sel1_q     <= '0;
            vld1_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_base_q  <= rd_base_d;
            wr_col_q   <= wr_col_d;
            line_cnt_q <= line_cnt_d;
            wr_ready_q <= wr_ready_d;
            rd_ready_q <= rd_ready_d;
            wr_ovf_q   <= wr_ovf_d;
            rd_unf_q   <= rd_unf_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            vld1_q     <= vld1_d;
        end
    end

    for (genvar g = 0; g < LINE_NUM; g++) begin : g_bank
        interp_lb_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (wr_acc_s & ~hold_s & (wr_ptr_q == PTR_W'(g))),
            .waddr_i (wr_col_q),
            .wdata_i (wr_data),
            .re_i    (rd_acc_s & ~hold_s),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata_s[g])
        );
    end

    // Pick the two read lines out of the bank outputs.
    always_comb begin
        mux0_s = '0;
        mux1_s = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if (sel0_q == PTR_W'(i)) begin
                mux0_s = bank_rdata_s[i];
            end else begin
                mux0_s = mux0_s;
            end
            if (sel1_q == PTR_W'(i)) begin
                mux1_s = bank_rdata_s[i];
            end else begin
                mux1_s = mux1_s;
            end
        end
    end

`ifdef INTERP_LB_OUTREG_EN
    logic                  vld2_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;

    // Output stage: retime the mux result and delay valid to match.
    always_ff @(posedge clk) begin
        if (rst || sof) begin
            vld2_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                data0_q <= mux0_s;
                data1_q <= mux1_s;
            end else begin
                data0_q <= data0_q;
                data1_q <= data1_q;
            end
        end
    end

    assign rd_valid = vld2_q;
    assign rd_data0 = data0_q;
    assign rd_data1 = data1_q;
`else
    // RAM read registers drive the outputs directly; masked to zero while
    // idle so the port shows the reset value rather than stale bank data.
    assign rd_valid = vld1_q;
    assign rd_data0 = vld1_q ? mux0_s : '0;
    assign rd_data1 = vld1_q ? mux1_s : '0;
`endif

    assign wr_ready = wr_ready_q;
    assign rd_ready = rd_ready_q;
    assign line_cnt = line_cnt_q;
    assign wr_ovf   = wr_ovf_q;
    assign rd_unf   = rd_unf_q;

endmodule

// File: tb/tb_interpolation_line_buffer.sv
// Self-checking bench for interpolation_line_buffer (LINE_NUM=4).
module tb_interpolation_line_buffer;
    import interp_lb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 11;
    localparam int LN = 4;
    localparam int CW = $clog2(LN + 1);

    logic          clk = 1'b0;
    logic          rst, sof, wr_en, wr_line_done, rd_en, rd_line_adv;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic          wr_ready, rd_ready, rd_valid, wr_ovf, rd_unf;
    logic [DW-1:0] rd_data0, rd_data1;
    logic [CW-1:0] line_cnt;

    always #5 clk = ~clk;

    interpolation_line_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_NUM(LN)
    ) dut (
        .clk(clk), .rst(rst), .sof(sof),
        .wr_en(wr_en), .wr_data(wr_data), .wr_line_done(wr_line_done),
        .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_line_adv(rd_line_adv),
        .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .line_cnt(line_cnt), .wr_ovf(wr_ovf), .rd_unf(rd_unf)
    );

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            due;
    } exp_t;

    typedef struct {
        logic [AW-1:0] col;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } rd_vec_t;

    exp_t    sbq[$];
    rd_vec_t vecs[6];
    int      cyc = 0;
    int      n_pass = 0;
    int      n_total = 0;

    // Behavioural model of the ring.
    logic [DW-1:0] mmem [LN][256];
    int            m_wp, m_rb, m_col, m_cnt;
    logic          m_ovf, m_unf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard consumer: every rd_valid must match the oldest due entry.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0 || sbq[0].due != cyc) begin
                n_total++;
                $display("FAIL rd_valid_unexpected: rd_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sbq.pop_front();
                check("rd_data0", 32'(rd_data0), 32'(e.d0));
                check("rd_data1", 32'(rd_data1), 32'(e.d1));
            end
        end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            n_total++;
            $display("FAIL rd_valid_missing: rd_valid=%b at cycle %0d, expected 1", rd_valid, cyc);
        end
    end

    task automatic model_clear();
        m_wp = 0; m_rb = 0; m_col = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic flush_future();
        for (int i = sbq.size() - 1; i >= 0; i--)
            if (sbq[i].due > cyc) sbq.delete(i);
    endtask

    // Drive one cycle of stimulus and advance the model using pre-edge state.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic wld,
                        input logic re, input logic [AW-1:0] ra, input logic adv,
                        input logic use_tab, input logic [DW-1:0] t0, input logic [DW-1:0] t1);
        bit   wr_rdy, rd_rdy;
        int   cnt0;
        exp_t e;
        wr_rdy = (m_cnt < LN);
        rd_rdy = (m_cnt >= 2);
        cnt0   = m_cnt;
        wr_en = we; wr_data = wd; wr_line_done = wld;
        rd_en = re; rd_addr = ra; rd_line_adv = adv;
        if (re) begin
            if (rd_rdy) begin
                e.d0  = use_tab ? t0 : mmem[m_rb][ra[7:0]];
                e.d1  = use_tab ? t1 : mmem[(m_rb + 1) % LN][ra[7:0]];
                e.due = cyc + int'(RD_LAT);
                sbq.push_back(e);
            end else m_unf = 1'b1;
        end
        if (we) begin
            if (wr_rdy) begin
                mmem[m_wp][m_col % 256] = wd;
                m_col++;
            end else m_ovf = 1'b1;
        end
        if (wld) begin
            if (wr_rdy) begin
                m_wp = (m_wp + 1) % LN; m_col = 0; m_cnt++;
            end else m_ovf = 1'b1;
        end
        if (adv) begin
            if (cnt0 > 0) begin
                m_rb = (m_rb + 1) % LN; m_cnt--;
            end else m_unf = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0; wr_line_done = 1'b0; rd_en = 1'b0; rd_line_adv = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic ctrl(input logic r, input logic s);
        rst = r; sof = s;
        flush_future();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0; sof = 1'b0;
    endtask

    task automatic write_line(input int l, input int len, input logic adv_last);
        for (int c = 0; c < len; c++)
            step(1'b1, DW'(l * 16 + c), c == len - 1, 1'b0, '0,
                 adv_last && (c == len - 1), 1'b0, '0, '0);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_line_cnt"}, 32'(line_cnt), 32'(m_cnt));
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'(m_cnt < LN));
        check({tag, "_rd_ready"}, 32'(rd_ready), 32'(m_cnt >= 2));
        check({tag, "_wr_ovf"},   32'(wr_ovf),   32'(m_ovf));
        check({tag, "_rd_unf"},   32'(rd_unf),   32'(m_unf));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        check({tag, "_rd_ready"}, 32'(rd_ready), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data0"}, 32'(rd_data0), 32'd0);
        check({tag, "_rd_data1"}, 32'(rd_data1), 32'd0);
        check({tag, "_wr_ovf"},   32'(wr_ovf),   32'd0);
        check({tag, "_rd_unf"},   32'(rd_unf),   32'd0);
    endtask

    initial begin
        vecs[0] = '{col: 11'd3, e0: 16'h0003, e1: 16'h0013};
        vecs[1] = '{col: 11'd0, e0: 16'h0000, e1: 16'h0010};
        vecs[2] = '{col: 11'd7, e0: 16'h0007, e1: 16'h0017};
        vecs[3] = '{col: 11'd1, e0: 16'h0001, e1: 16'h0011};
        vecs[4] = '{col: 11'd6, e0: 16'h0006, e1: 16'h0016};
        vecs[5] = '{col: 11'd3, e0: 16'h0003, e1: 16'h0013};

        rst = 1'b1; sof = 1'b0; wr_en = 1'b0; wr_data = '0; wr_line_done = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_line_adv = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Fill the ring: 4 lines of 8 pixels, value = line*16+col.
        for (int l = 0; l < LN; l++) write_line(l, 8, 1'b0);
        check("full_line_cnt", 32'(line_cnt), 32'd4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_rd_ready", 32'(rd_ready), 32'd1);

        // Back-to-back table reads of lines 0/1.
        for (int i = 0; i < 6; i++)
            step(1'b0, '0, 1'b0, 1'b1, vecs[i].col, 1'b0, 1'b1, vecs[i].e0, vecs[i].e1);
        repeat (3) idle();

        // Write while full is rejected: line 0 col 0 must keep its value.
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check("ovf_flag", 32'(wr_ovf), 32'd1);
        check("ovf_line_cnt", 32'(line_cnt), 32'd4);
        step(1'b0, '0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b1, 16'h0000, 16'h0010);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        check("rel_line_cnt", 32'(line_cnt), 32'd3);
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 11'd3, 1'b0, 1'b1, 16'h0013, 16'h0023);
        repeat (3) idle();

        // Release to 2 lines, then commit and release together.
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0);
        check("two_line_cnt", 32'(line_cnt), 32'd2);
        write_line(4, 8, 1'b1);
        check("both_line_cnt", 32'(line_cnt), 32'd2);
        check("both_rd_ready", 32'(rd_ready), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 11'd3, 1'b0, 1'b1, 16'h0033, 16'h0043);
        repeat (3) idle();
        check_model("pre_stream");

        // Stream well past 2*LINE_NUM lines with reads mixed into writes.
        for (int l = 5; l < 15; l++) begin
            if (m_cnt == LN)
                step(1'b0, '0, 1'b0, 1'b1, AW'($urandom_range(0, 7)), 1'b1, 1'b0, '0, '0);
            for (int c = 0; c < 8; c++)
                step(1'b1, DW'(l * 16 + c), c == 7, m_cnt >= 2,
                     AW'($urandom_range(0, 7)), 1'b0, 1'b0, '0, '0);
        end
        repeat (3) idle();
        check_model("stream");

        // Drain to one line with read+release in the same cycle.
        for (int k = 0; k < LN && m_cnt > 1; k++)
            step(1'b0, '0, 1'b0, 1'b1, AW'($urandom_range(0, 7)), 1'b1, 1'b0, '0, '0);
        repeat (3) idle();
        check("drain_line_cnt", 32'(line_cnt), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 11'd2, 1'b0, 1'b0, '0, '0);
        check("unf_flag", 32'(rd_unf), 32'd1);
        repeat (3) idle();

        // Frame start clears pointers, count and flags.
        ctrl(1'b0, 1'b1);
        check_reset_outputs("sof");

        // Reset with a read in flight.
        write_line(10, 2, 1'b0);
        write_line(11, 2, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 11'd1, 1'b0, 1'b1, 16'h00A1, 16'h00B1);
        ctrl(1'b1, 1'b0);
        check_reset_outputs("rst_inflight");
        repeat (4) idle();
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
